// File: rtl/xgmii_rx_decoder_if.sv
// XGMII receive lanes in, Avalon-ST frame words out.
// The decoder side uses master; the consumer side uses slave.
interface xgmii_rx_decoder_if;
  localparam int unsigned XGMII_W = 72;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned EMPTY_W = 3;
  localparam int unsigned ERR_W   = 3;
  localparam int unsigned LEN_W   = 16;

  logic [XGMII_W-1:0] xgmii_rx_data;
  logic               rx_valid;
  logic               rx_startofpacket;
  logic               rx_endofpacket;
  logic [DATA_W-1:0]  rx_data;
  logic [EMPTY_W-1:0] rx_empty;
  logic [ERR_W-1:0]   rx_error;
  logic [LEN_W-1:0]   rx_len;
  logic               stat_drop;

  modport master (
    input  xgmii_rx_data,
    output rx_valid, rx_startofpacket, rx_endofpacket, rx_data,
    output rx_empty, rx_error, rx_len, stat_drop
  );

  modport slave (
    output xgmii_rx_data,
    input  rx_valid, rx_startofpacket, rx_endofpacket, rx_data,
    input  rx_empty, rx_error, rx_len, stat_drop
  );
endinterface

// File: rtl/xgmii_rx_decoder.sv
// XGMII 72-bit SDR receive decoder: strips start/preamble, finds terminate,
// emits 64-bit Avalon-ST words with length and error status on EOP.
module xgmii_rx_decoder #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input logic               clk_156_25,
  input logic               rst,
  xgmii_rx_decoder_if.master bus
);
  localparam int unsigned LANES = 8;
  localparam logic [7:0]  C_START = 8'hFB;
  localparam logic [7:0]  C_TERM  = 8'hFD;

  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

  state_t      state;
  logic [63:0] hold_data;
  logic        hold_valid;
  logic        hold_eop;
  logic [2:0]  hold_empty;
  logic        hold_err;
  logic        first;
  logic [15:0] len_cnt;

  logic [7:0]  byt [LANES];
  logic [7:0]  ctl;
  logic        k_found;
  logic [2:0]  k_idx;
  logic [63:0] word_full;
  logic [63:0] word_part;
  logic        start_any;
  logic        start_ok;
  logic        term_any;

  // Lane unpacking, lowest control lane, start/terminate detection
  always_comb begin
    k_found   = 1'b0;
    k_idx     = 3'd0;
    word_full = 64'd0;
    word_part = 64'd0;
    term_any  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      byt[i] = bus.xgmii_rx_data[9*i +: 8];
      ctl[i] = bus.xgmii_rx_data[9*i + 8];
    end
    for (int i = 7; i >= 0; i--) begin
      if (ctl[i]) begin
        k_found = 1'b1;
        k_idx   = 3'(i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      word_full[63-8*i -: 8] = byt[i];
      word_part[63-8*i -: 8] = (3'(i) < k_idx) ? byt[i] : 8'd0;
      if (ctl[i] && byt[i] == C_TERM) term_any = 1'b1;
    end
    start_any = ctl[0] && byt[0] == C_START;
    start_ok  = start_any && ctl[7:1] == 7'd0 && byt[7] == 8'hD5;
    for (int i = 1; i < 7; i++) begin
      if (byt[i] != 8'h55) start_ok = 1'b0;
    end
  end

  logic        emit_v;
  logic        emit_eop;
  logic [2:0]  emit_empty;
  logic        emit_cerr;
  logic [3:0]  emit_bytes;
  logic [16:0] len_sum;
  logic [15:0] len_new;

  // Selects what leaves the hold register this cycle and the running length
  always_comb begin
    emit_v     = 1'b0;
    emit_eop   = 1'b0;
    emit_empty = 3'd0;
    emit_cerr  = 1'b0;
    emit_bytes = 4'd8;
    if (hold_valid && hold_eop) begin
      emit_v     = 1'b1;
      emit_eop   = 1'b1;
      emit_empty = hold_empty;
      emit_cerr  = hold_err;
      emit_bytes = 4'd8 - {1'b0, hold_empty};
    end else if (state == DATA && hold_valid) begin
      emit_v    = 1'b1;
      emit_eop  = k_found && k_idx == 3'd0;
      emit_cerr = emit_eop && byt[0] != C_TERM;
    end
    len_sum = {1'b0, len_cnt} + 17'(emit_bytes);
    len_new = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  end

  always_ff @(posedge clk_156_25) begin
    if (rst) begin
      state                <= IDLE;
      hold_data            <= 64'd0;
      hold_valid           <= 1'b0;
      hold_eop             <= 1'b0;
      hold_empty           <= 3'd0;
      hold_err             <= 1'b0;
      first                <= 1'b0;
      len_cnt              <= 16'd0;
      bus.rx_valid         <= 1'b0;
      bus.rx_startofpacket <= 1'b0;
      bus.rx_endofpacket   <= 1'b0;
      bus.rx_data          <= 64'd0;
      bus.rx_empty         <= 3'd0;
      bus.rx_error         <= 3'd0;
      bus.rx_len           <= 16'd0;
      bus.stat_drop        <= 1'b0;
    end else begin
      bus.rx_valid         <= 1'b0;
      bus.rx_startofpacket <= 1'b0;
      bus.rx_endofpacket   <= 1'b0;
      bus.rx_data          <= 64'd0;
      bus.rx_empty         <= 3'd0;
      bus.rx_error         <= 3'd0;
      bus.rx_len           <= 16'd0;
      bus.stat_drop        <= 1'b0;

      if (emit_v) begin
        bus.rx_valid         <= 1'b1;
        bus.rx_data          <= hold_data;
        bus.rx_startofpacket <= first;
        bus.rx_endofpacket   <= emit_eop;
        first                <= 1'b0;
        if (emit_eop) begin
          bus.rx_empty <= emit_empty;
          bus.rx_len   <= len_new;
          bus.rx_error <= {32'(len_new) > MAX_LEN, 32'(len_new) < MIN_LEN, emit_cerr};
          len_cnt      <= 16'd0;
        end else begin
          len_cnt <= len_new;
        end
      end

      // A pending partial EOP word always drains in the cycle after it was loaded
      if (hold_eop) begin
        hold_valid <= 1'b0;
        hold_eop   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_any) begin
            if (start_ok) begin
              state      <= DATA;
              first      <= 1'b1;
              hold_valid <= 1'b0;
            end else begin
              state         <= DROP;
              bus.stat_drop <= 1'b1;
            end
          end
        end
        DATA: begin
          if (!k_found) begin
            hold_data  <= word_full;
            hold_valid <= 1'b1;
          end else begin
            state <= IDLE;
            if (k_idx == 3'd0) begin
              hold_valid <= 1'b0;
              if (!hold_valid) bus.stat_drop <= 1'b1;
            end else begin
              hold_data  <= word_part;
              hold_valid <= 1'b1;
              hold_eop   <= 1'b1;
              hold_empty <= 3'(4'd8 - {1'b0, k_idx});
              hold_err   <= byt[k_idx] != C_TERM;
            end
          end
        end
        DROP: begin
          if (term_any) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xgmii_rx_decoder.sv
// Scoreboard bench for xgmii_rx_decoder: directed frames push expected words,
// a negedge monitor pops and compares every valid output word.
module tb_xgmii_rx_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   drops_seen = 0;
  int   drops_exp = 0;

  typedef struct {
    logic        sop;
    logic        eop;
    logic [63:0] data;
    logic [2:0]  empty;
    logic [2:0]  err;
    logic [15:0] len;
    int          at;
  } exp_t;

  exp_t exp_q [$];

  xgmii_rx_decoder_if bus ();

  xgmii_rx_decoder #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk_156_25(clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [71:0] IDLE_WORD = {8{1'b1, 8'h07}};

  // Monitor: every valid word must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.stat_drop) drops_seen++;
    if (bus.rx_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data=%h sop=%0b eop=%0b at cycle %0d, none expected",
                 bus.rx_data, bus.rx_startofpacket, bus.rx_endofpacket, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.rx_startofpacket !== e.sop || bus.rx_endofpacket !== e.eop ||
            bus.rx_data !== e.data || bus.rx_empty !== e.empty ||
            bus.rx_error !== e.err || bus.rx_len !== e.len || cyc != e.at) begin
          errors++;
          $display("FAIL word: got sop=%0b eop=%0b data=%h empty=%0d err=%b len=%0d cyc=%0d; expected sop=%0b eop=%0b data=%h empty=%0d err=%b len=%0d cyc=%0d",
                   bus.rx_startofpacket, bus.rx_endofpacket, bus.rx_data, bus.rx_empty,
                   bus.rx_error, bus.rx_len, cyc, e.sop, e.eop, e.data, e.empty, e.err, e.len, e.at);
        end
      end
    end
  end

  task automatic drive(input logic [71:0] w);
    @(posedge clk);
    #1;
    bus.xgmii_rx_data = w;
  endtask

  function automatic logic [71:0] start_word(input bit bad_sfd);
    logic [71:0] w;
    w = {1'b0, 8'hD5, {6{1'b0, 8'h55}}, 1'b1, 8'hFB};
    if (bad_sfd) w[71:63] = {1'b0, 8'h55};
    return w;
  endfunction

  // Sends one frame; expected words are queued unless the frame will be dropped
  task automatic send_frame(input int nbytes, input bit bad_sfd, input logic [7:0] tcode,
                            input int seed, input int gap);
    int nfull, r, j, len;
    logic [71:0] w;
    exp_t e;
    logic [2:0] err;
    nfull = nbytes / 8;
    r     = nbytes % 8;
    j     = 0;
    len   = (nbytes > 65535) ? 65535 : nbytes;
    err   = {len > 1518, len < 64, tcode != 8'hFD};
    drive(start_word(bad_sfd));
    if (bad_sfd || nbytes == 0) drops_exp++;
    for (int wi = 0; wi < nfull; wi++) begin
      e.data = 64'd0;
      for (int i = 0; i < 8; i++) begin
        logic [7:0] b;
        b = 8'(seed + 3 * j);
        j++;
        w[9*i +: 9] = {1'b0, b};
        e.data[63-8*i -: 8] = b;
      end
      e.sop   = (wi == 0);
      e.eop   = (r == 0 && wi == nfull - 1);
      e.empty = 3'd0;
      e.err   = e.eop ? err : 3'd0;
      e.len   = e.eop ? 16'(len) : 16'd0;
      drive(w);
      e.at = cyc + 2;
      if (!bad_sfd) exp_q.push_back(e);
    end
    w = IDLE_WORD;
    e.data = 64'd0;
    for (int i = 0; i < r; i++) begin
      logic [7:0] b;
      b = 8'(seed + 3 * j);
      j++;
      w[9*i +: 9] = {1'b0, b};
      e.data[63-8*i -: 8] = b;
    end
    w[9*r +: 9] = {1'b1, tcode};
    drive(w);
    if (r != 0 && !bad_sfd) begin
      e.sop   = (nfull == 0);
      e.eop   = 1'b1;
      e.empty = 3'(8 - r);
      e.err   = err;
      e.len   = 16'(len);
      e.at    = cyc + 2;
      exp_q.push_back(e);
    end
    for (int g = 0; g < gap; g++) drive(IDLE_WORD);
  endtask

  initial begin
    bus.xgmii_rx_data = IDLE_WORD;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.rx_valid !== 1'b0 || bus.rx_startofpacket !== 1'b0 || bus.rx_endofpacket !== 1'b0 ||
        bus.rx_data !== 64'd0 || bus.rx_empty !== 3'd0 || bus.rx_error !== 3'd0 ||
        bus.rx_len !== 16'd0 || bus.stat_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b data=%h len=%0d err=%b, expected all zero",
               bus.rx_valid, bus.rx_data, bus.rx_len, bus.rx_error);
    end
    rst = 1'b0;
    drive(IDLE_WORD);

    send_frame(64, 1'b0, 8'hFD, 8'h10, 2);   // T in lane 0
    send_frame(65, 1'b0, 8'hFD, 8'h20, 2);   // T in lane 1
    send_frame(64, 1'b1, 8'hFD, 8'h30, 1);   // bad SFD, dropped
    send_frame(64, 1'b0, 8'hFD, 8'h40, 1);   // good frame after drop
    send_frame(67, 1'b0, 8'hFE, 8'h50, 2);   // bad terminate code
    send_frame(40, 1'b0, 8'hFD, 8'h60, 2);   // runt
    send_frame(1600, 1'b0, 8'hFD, 8'h70, 2); // oversize, forwarded in full
    send_frame(5, 1'b0, 8'hFD, 8'h80, 2);    // single word with SOP and EOP
    send_frame(0, 1'b0, 8'hFD, 8'h90, 2);    // empty frame, dropped
    send_frame(65, 1'b0, 8'hFD, 8'hA0, 0);   // pending EOP overlaps next start
    send_frame(70, 1'b0, 8'hFD, 8'hB0, 2);

    // Reset during the 4th data word: only the first two words may appear
    begin
      logic [71:0] w;
      exp_t e;
      drive(start_word(1'b0));
      for (int wi = 0; wi < 4; wi++) begin
        e.data = 64'd0;
        for (int i = 0; i < 8; i++) begin
          logic [7:0] b;
          b = 8'(8'hC0 + 8 * wi + i);
          w[9*i +: 9] = {1'b0, b};
          e.data[63-8*i -: 8] = b;
        end
        drive(w);
        if (wi == 3) rst = 1'b1;
        e.sop = (wi == 0); e.eop = 1'b0; e.empty = 3'd0; e.err = 3'd0; e.len = 16'd0;
        e.at = cyc + 2;
        if (wi < 2) exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.xgmii_rx_data = IDLE_WORD;
      checks++;
      if (bus.rx_valid !== 1'b0 || bus.rx_endofpacket !== 1'b0 || bus.rx_data !== 64'd0 ||
          bus.rx_len !== 16'd0 || bus.stat_drop !== 1'b0) begin
        errors++;
        $display("FAIL reset_midframe: got valid=%0b eop=%0b data=%h len=%0d, expected all zero",
                 bus.rx_valid, bus.rx_endofpacket, bus.rx_data, bus.rx_len);
      end
    end
    send_frame(64, 1'b0, 8'hFD, 8'hD0, 2);

    repeat (10) drive(IDLE_WORD);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_words: got %0d expected words never seen, required 0", exp_q.size());
    end
    checks++;
    if (drops_seen != drops_exp) begin
      errors++;
      $display("FAIL stat_drop: got %0d pulses, required %0d", drops_seen, drops_exp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xgmii_rx_decoder.md
# xgmii_rx_decoder

Decodes the 72-bit single-data-rate XGMII stream into 64-bit Avalon-ST frames. It strips the start word, checks the preamble and SFD, finds the terminate lane, and reports length and error status per frame. It sits on the PHY side of the 10G datapath, on the 156.25 MHz XGMII clock. It consumes the same lane format the MAC drives toward the PHY, so it serves both as the loopback checker for the MAC transmit path and as a lightweight receive path.

## Interface
Parameters:
- MIN_LEN, 64: minimum legal frame length in bytes, CRC included.
- MAX_LEN, 1518: maximum legal frame length in bytes, CRC included.

Ports:
- clk_156_25  in  1  XGMII clock; one clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- xgmii_rx_data  in  72  eight lanes of 9 bits each. Lane i is [9i+8:9i]: bit 9i+8 is the control flag, [9i+7:9i] is the byte. Lane 0 is first on the wire.
- rx_valid  out  1  output word valid. No backpressure.
- rx_startofpacket  out  1  first word of frame.
- rx_endofpacket  out  1  last word of frame.
- rx_data  out  64  lane 0 byte maps to [63:56], lane 7 byte to [7:0].
- rx_empty  out  3  unused low-order bytes on the EOP word; 0 on all other words.
- rx_error  out  3  valid on the EOP word: [0] code error, [1] runt, [2] oversize.
- rx_len  out  16  frame byte count, valid on the EOP word, saturates at 65535.
- stat_drop  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Lowest control lane: k = the lowest lane whose control flag is set; none if no lane has it set.
- State IDLE: wait for lane 0 = control 0xFB.
  - Lanes 1–6 = data 0x55 and lane 7 = data 0xD5: go to DATA with first=1 and the hold register empty.
  - Any other preamble content: go to DROP and pulse stat_drop.
  - 0xFB in any lane other than 0 is ignored.
- State DATA, no control lane:
  - If hold is valid, emit the held word, with SOP = first, then clear first.
  - Load the current word into hold.
- State DATA, control at lane k:
  - The frame ends. Lanes 0..k-1 are the final data bytes.
  - Code error is set if lane k is not 0xFD.
  - k=0 with hold valid: emit hold with EOP and empty=0.
  - k>0: emit hold (non-EOP) if it is valid, then load the partial word into hold with pending-EOP and empty=8-k. The partial word is emitted on the next cycle, whatever state the FSM is in.
  - k=0 with hold empty (zero data bytes): nothing is emitted and stat_drop pulses.
  - Next state is IDLE.
- A frame of exactly one word with T in lane k>0 carries both SOP and EOP.
- State DROP: stay until a word contains control 0xFD in any lane, then go to IDLE.
- Length: a byte counter accumulates the data bytes of each emitted word.
  - rx_error[1] = len < MIN_LEN.
  - rx_error[2] = len > MAX_LEN.
  - Oversize frames are still forwarded in full.
- Partial words: data bytes are left-justified and the unused low bytes are driven to zero.

## Timing
- Reset values: rx_valid, rx_startofpacket, rx_endofpacket, stat_drop = 0; rx_data, rx_empty, rx_error, rx_len = 0; FSM = IDLE; hold, pending-EOP and counter cleared.
- All outputs are registered.
- Latency: a data word on xgmii_rx_data in cycle m appears on rx_data in cycle m+2. This holds for every word, including a partial EOP word and a held word closed by T in lane 0.
- rx_valid is high at most one cycle per input word. A gap of one cycle is allowed only at the start of each frame.
- A pending-EOP emission and a new 0xFB start word in the same cycle are both handled. The start word produces no output, so the two do not conflict.
- Reset asserted mid-frame: the next cycle shows reset values. No EOP is emitted for the aborted frame.
- rx_len and rx_error are meaningful only when rx_valid && rx_endofpacket. They are 0 on all other cycles.

## Test plan
- 64-byte frame: start word, 8 full data words, then T in lane 0 of the next word -> 8 valid words, SOP on the first, EOP on the eighth, empty=0, len=64, error=0, first output 2 cycles after the first data word.
- 65-byte frame: 8 full words, then a word with 1 data byte and T in lane 1 -> 9 words, EOP word empty=7, rx_data[55:0]=0, len=65, error=0.
- Bad SFD (lane 7 = 0x55) followed by 8 data words and T -> no rx_valid, a single stat_drop pulse, and the next good frame is decoded normally.
- 0xFE in lane 3 of the 9th word -> EOP word empty=5, rx_error[0]=1, len=67.
- 40-byte frame -> rx_error=3'b010, len=40. A 1600-byte frame -> rx_error=3'b100, len=1600, all 200 words emitted.
- rst pulsed for one cycle during the 4th data word -> all outputs 0 after the reset edge, no EOP, and a back-to-back following frame is decoded correctly.
